// File: rtl/jogador_automatico_if.sv
// -----------------------------------------------------------------------------
// jogador_automatico_if
//
// Bundles every signal exchanged between the automatic player and the
// memory game (plus its status/debug outputs). Clock and reset are kept as
// plain ports on the modules that use this interface.
//
// Optional feature macro: ERRO_PROPOSITAL_EN adds the 'erra' input.
//
// Signals:
//   iniciar      start request towards the player
//   leds   [3:0] game LED outputs observed by the player
//   ganhou       game won
//   perdeu       game lost
//   erra         (ERRO_PROPOSITAL_EN only) corrupt the last item of replays
//   jogar        start pulse from the player to the game
//   botoes [3:0] button drive from the player to the game
//   ativo        player busy (not INICIAL / FIM)
//   resultado    00 none, 01 won, 10 lost
//   overflow     sticky: a round showed more items than the buffer holds
//   db_estado    player state encoding
//   db_contagem  items captured in the current round
//
// Modports:
//   master  the player side (jogador_automatico)
//   slave   the game / environment side
// -----------------------------------------------------------------------------
interface jogador_automatico_if;
  logic       iniciar;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
`ifdef ERRO_PROPOSITAL_EN
  logic       erra;
`endif
  logic       jogar;
  logic [3:0] botoes;
  logic       ativo;
  logic [1:0] resultado;
  logic       overflow;
  logic [3:0] db_estado;
  logic [4:0] db_contagem;

  modport master (
`ifdef ERRO_PROPOSITAL_EN
    input  erra,
`endif
    input  iniciar, leds, ganhou, perdeu,
    output jogar, botoes, ativo, resultado, overflow, db_estado, db_contagem
  );

  modport slave (
`ifdef ERRO_PROPOSITAL_EN
    output erra,
`endif
    output iniciar, leds, ganhou, perdeu,
    input  jogar, botoes, ativo, resultado, overflow, db_estado, db_contagem
  );
endinterface

// File: rtl/jogador_automatico.sv
// -----------------------------------------------------------------------------
// jogador_automatico
//
// Automatic player for the memory game. It pulses 'jogar' to start a game,
// captures the one-hot LED sequence shown each round into a small buffer and
// replays it on 'botoes' with fixed press/release timing, round after round,
// until the game reports ganhou or perdeu.
//
// Optional feature macro: ERRO_PROPOSITAL_EN. When defined the interface
// carries 'erra'; with erra=1 the last item of every replay is rotated left by
// one bit (1000 -> 0001) so the game's loss path can be exercised. When not
// defined the replay is always exact.
//
// Parameters:
//   DEPTH         maximum items captured per round
//   HOLD          cycles each button stays pressed
//   GAP           cycles of all-zero botoes after each press
//   IDLE          consecutive leds==0 cycles (after a capture) that end capture
//   JOGAR_CYCLES  width of the jogar pulse
//
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high; clears all state
//   bus    jogador_automatico_if.master (see the interface for signal list)
// -----------------------------------------------------------------------------
module jogador_automatico #(
  parameter int DEPTH        = 16,
  parameter int HOLD         = 10,
  parameter int GAP          = 10,
  parameter int IDLE         = 100,
  parameter int JOGAR_CYCLES = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  jogador_automatico_if.master    bus
);

  localparam int CW   = $clog2(DEPTH) + 1;           // item counter width
  localparam int AW   = $clog2(DEPTH);               // buffer address width
  localparam int TMAX = (HOLD > GAP) ? ((HOLD > JOGAR_CYCLES) ? HOLD : JOGAR_CYCLES)
                                     : ((GAP  > JOGAR_CYCLES) ? GAP  : JOGAR_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);            // shared phase timer width
  localparam int IW   = $clog2(IDLE + 1);            // idle counter width

  localparam logic [3:0] S_INICIAL     = 4'd0;
  localparam logic [3:0] S_PULSA_JOGAR = 4'd1;
  localparam logic [3:0] S_ESPERA_LED  = 4'd2;
  localparam logic [3:0] S_CAPTURA     = 4'd3;
  localparam logic [3:0] S_PRESSIONA   = 4'd4;
  localparam logic [3:0] S_SOLTA       = 4'd5;
  localparam logic [3:0] S_FIM         = 4'd15;

  logic [3:0]    r_estado;
  logic [TW-1:0] r_timer;
  logic [IW-1:0] r_idle;
  logic [CW-1:0] r_contagem;
  logic [CW-1:0] r_idx;
  logic [3:0]    r_leds_prev;
  logic          r_jogar;
  logic [3:0]    r_botoes;
  logic [1:0]    r_resultado;
  logic          r_overflow;
  logic [3:0]    r_buf [DEPTH];

  logic          w_um_quente;
  logic          w_borda;
  logic          w_desfecho;
  logic          w_cheio;
  logic          w_grava;
  logic [AW-1:0] w_end_escrita;
  logic [CW-1:0] w_idx_prox;
  logic [AW-1:0] w_end_leitura;
  logic [3:0]    w_lido;
  logic [3:0]    w_item;

  // A capture is the 0000 -> one-hot transition of leds. Non-one-hot values
  // never qualify, and a value reached from another nonzero value does not
  // qualify either, so nothing is captured until leds returns to zero.
  assign w_um_quente = (bus.leds != 4'd0) && ((bus.leds & (bus.leds - 4'd1)) == 4'd0);
  assign w_borda     = (r_leds_prev == 4'd0) && w_um_quente;

  // The game's verdict overrides everything except the idle and final states.
  assign w_desfecho  = (bus.ganhou | bus.perdeu) &&
                       (r_estado != S_INICIAL) && (r_estado != S_FIM);

  assign w_cheio     = (r_contagem == CW'(DEPTH));

  // The first capture of a round always lands at index 0; later ones append
  // until the buffer is full, after which they are dropped.
  assign w_grava       = w_borda && !w_desfecho &&
                         ((r_estado == S_ESPERA_LED) ||
                          ((r_estado == S_CAPTURA) && !w_cheio));
  assign w_end_escrita = (r_estado == S_ESPERA_LED) ? '0 : r_contagem[AW-1:0];

  // Item for the next press: index 0 when leaving CAPTURA, idx+1 when
  // leaving SOLTA. The value is latched into r_botoes on state entry.
  assign w_idx_prox    = r_idx + CW'(1);
  assign w_end_leitura = (r_estado == S_SOLTA) ? w_idx_prox[AW-1:0] : '0;
  assign w_lido        = r_buf[w_end_leitura];

`ifdef ERRO_PROPOSITAL_EN
  logic w_ultimo;
  assign w_ultimo = (r_estado == S_SOLTA) ? ((w_idx_prox + CW'(1)) == r_contagem)
                                          : (r_contagem == CW'(1));
  assign w_item   = (bus.erra && w_ultimo) ? {w_lido[2:0], w_lido[3]} : w_lido;
`else
  assign w_item   = w_lido;
`endif

  // NOTE: the capture buffer has no reset; its contents are only read at
  // indices written earlier in the same round, so clearing it buys nothing.
  always_ff @(posedge clock) begin
    if (w_grava) begin
      r_buf[w_end_escrita] <= bus.leds;
    end
  end

  // NOTE: every state register is updated with non-blocking assignments so
  // all of them see the same pre-edge values of each other.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= S_INICIAL;
      r_timer     <= '0;
      r_idle      <= '0;
      r_contagem  <= '0;
      r_idx       <= '0;
      r_leds_prev <= 4'd0;
      r_jogar     <= 1'b0;
      r_botoes    <= 4'd0;
      r_resultado <= 2'b00;
      r_overflow  <= 1'b0;
    end else begin
      r_leds_prev <= bus.leds;

      if (w_desfecho) begin
        r_estado    <= S_FIM;
        r_botoes    <= 4'd0;
        r_jogar     <= 1'b0;
        // Loss wins over a simultaneous win.
        r_resultado <= {bus.perdeu, bus.ganhou & ~bus.perdeu};
      end else begin
        case (r_estado)
          S_INICIAL, S_FIM: begin
            if (bus.iniciar) begin
              r_estado    <= S_PULSA_JOGAR;
              r_jogar     <= 1'b1;
              r_timer     <= '0;
              r_contagem  <= '0;
              r_overflow  <= 1'b0;
              r_resultado <= 2'b00;
            end
          end

          S_PULSA_JOGAR: begin
            if (r_timer == TW'(JOGAR_CYCLES - 1)) begin
              r_jogar  <= 1'b0;
              r_timer  <= '0;
              r_estado <= S_ESPERA_LED;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end

          S_ESPERA_LED: begin
            if (w_borda) begin
              r_contagem <= CW'(1);
              r_idle     <= '0;
              r_estado   <= S_CAPTURA;
            end
          end

          S_CAPTURA: begin
            if (w_borda) begin
              if (w_cheio) begin
                r_overflow <= 1'b1;
              end else begin
                r_contagem <= r_contagem + CW'(1);
              end
            end
            // Any nonzero leds (captured or not) restarts the idle window.
            if (bus.leds != 4'd0) begin
              r_idle <= '0;
            end else if (r_idle == IW'(IDLE - 1)) begin
              r_idle   <= '0;
              r_idx    <= '0;
              r_timer  <= '0;
              r_botoes <= w_item;
              r_estado <= S_PRESSIONA;
            end else begin
              r_idle <= r_idle + IW'(1);
            end
          end

          S_PRESSIONA: begin
            if (r_timer == TW'(HOLD - 1)) begin
              r_timer  <= '0;
              r_botoes <= 4'd0;
              r_estado <= S_SOLTA;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end

          S_SOLTA: begin
            if (r_timer == TW'(GAP - 1)) begin
              r_timer <= '0;
              r_idx   <= w_idx_prox;
              if (w_idx_prox == r_contagem) begin
                r_estado <= S_ESPERA_LED;
              end else begin
                r_botoes <= w_item;
                r_estado <= S_PRESSIONA;
              end
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end

          default: begin
            r_estado <= S_INICIAL;
            r_botoes <= 4'd0;
            r_jogar  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.jogar       = r_jogar;
  assign bus.botoes      = r_botoes;
  assign bus.ativo       = (r_estado != S_INICIAL) && (r_estado != S_FIM);
  assign bus.resultado   = r_resultado;
  assign bus.overflow    = r_overflow;
  assign bus.db_estado   = r_estado;
  assign bus.db_contagem = 5'(r_contagem);

endmodule
